// File: rtl/reg_bus_pkg.sv
// Shared types and default sizes for the register-bus initiator.
//   reg_cmd_t          : one queued command (write flag, address, write data)
//   initiator_state_t  : transaction sequencer states
package reg_bus_pkg;

   localparam int REG_ADDR_W    = 8;
   localparam int REG_DATA_W    = 16;
   localparam int REG_CMD_DEPTH = 4;
   localparam int REG_TIMEOUT   = 16;

   typedef struct packed {
      logic                  write;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] wdata;
   } reg_cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } initiator_state_t;

endpackage

// File: rtl/reg_bus_initiator_if.sv
// Signal bundle for the register-bus initiator.
//   cmd_*  : command port (valid/ready), into the initiator
//   rsp_*  : response port (valid/ready), out of the initiator
//   bus_*  : register-bus handshake toward the slave register blocks
// Modports:
//   master : the initiator's view
//   slave  : the view of whatever surrounds it (command source, response
//            sink and the register slave)
interface reg_bus_initiator_if
   import reg_bus_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ack;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready,
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready,
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/reg_cmd_fifo.sv
// Command FIFO for the register-bus initiator.
//   clk, rst   : clock, asynchronous active-high reset
//   i_push     : write i_data (taken when not full, or when full and popping)
//   i_pop      : drop the head entry (ignored when empty)
//   o_data     : head entry, valid while !o_empty
//   o_full     : no free slot
//   o_empty    : nothing queued
// Pointers carry one extra wrap bit so full and empty are distinguishable
// with DEPTH a power of two.
module reg_cmd_fifo
   import reg_bus_pkg::*;
#(
   parameter int  DEPTH = REG_CMD_DEPTH,
   parameter type T     = reg_cmd_t
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   T            r_mem [DEPTH];
   logic        w_wr_en;
   logic        w_rd_en;

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign w_rd_en = i_pop && !o_empty;
   assign w_wr_en = i_push && (!o_full || w_rd_en);

   assign o_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/reg_bus_initiator.sv
// Synthesizable register-bus master.
//   clk, rst : clock, asynchronous active-high reset
//   bus_if   : master modport carrying the command port, the response port
//              and the register-bus handshake
// Commands are queued, issued one at a time as a single-cycle bus_req, and
// answered in order with read data and a timeout flag.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | nothing in flight; pops the next command when one is queued
//   REQ   | bus_req high for this single cycle; ack may already arrive
//   WAIT  | request held on the bus, counting cycles until ack or timeout
//   RESP  | response presented until the consumer takes it
module reg_bus_initiator
   import reg_bus_pkg::*;
#(
   parameter int ADDR_W    = REG_ADDR_W,
   parameter int DATA_W    = REG_DATA_W,
   parameter int CMD_DEPTH = REG_CMD_DEPTH,
   parameter int TIMEOUT   = REG_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   reg_bus_initiator_if.master bus_if
);

   localparam int                CNT_W       = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   initiator_state_t  r_state;
   initiator_state_t  w_state_nxt;

   cmd_t              w_push_data;
   cmd_t              w_head;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;

   logic              w_done;
   logic              w_timeout_err;
   logic [CNT_W-1:0]  r_cnt;

   logic              r_bus_we;
   logic [ADDR_W-1:0] r_bus_addr;
   logic [DATA_W-1:0] r_bus_wdata;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   assign w_push      = bus_if.cmd_valid && !w_full;
   assign w_push_data = {bus_if.cmd_write, bus_if.cmd_addr, bus_if.cmd_wdata};

   reg_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .T     (cmd_t)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_done        = 1'b0;
      w_timeout_err = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus_if.bus_ack) begin
               w_done      = 1'b1;
               w_state_nxt = RESP;
            end else begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            // Ack is tested first so that an ack on the final cycle still wins.
            if (bus_if.bus_ack) begin
               w_done      = 1'b1;
               w_state_nxt = RESP;
            end else if (r_cnt == TIMEOUT_CNT) begin
               w_done        = 1'b1;
               w_timeout_err = 1'b1;
               w_state_nxt   = RESP;
            end
         end
         RESP: begin
            if (bus_if.rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // r_cnt counts cycles since the request: 1 on the first WAIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == REQ) begin
         r_cnt <= CNT_W'(1);
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else begin
         r_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         if (w_pop) begin
            r_bus_we    <= w_head.write;
            r_bus_addr  <= w_head.addr;
            r_bus_wdata <= w_head.wdata;
         end
         if (w_done) begin
            r_rsp_err   <= w_timeout_err;
            r_rsp_rdata <= (w_timeout_err || r_bus_we) ? '0 : bus_if.bus_rdata;
         end
      end
   end

   assign bus_if.cmd_ready = !w_full;
   assign bus_if.bus_req   = (r_state == REQ);
   assign bus_if.bus_we    = r_bus_we;
   assign bus_if.bus_addr  = r_bus_addr;
   assign bus_if.bus_wdata = r_bus_wdata;
   assign bus_if.rsp_valid = (r_state == RESP);
   assign bus_if.rsp_rdata = r_rsp_rdata;
   assign bus_if.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Self-checking bench for reg_bus_initiator: a command driver, a slave model
// with a per-command ack delay plan, a response-ready driver and a response
// monitor fed by a scoreboard queue.
module tb_reg_bus_initiator;
   import reg_bus_pkg::*;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 16;
   localparam int CMD_DEPTH = 4;
   localparam int TIMEOUT   = 16;
   localparam int NEVER     = 1000;

   typedef struct packed {
      logic        we;
      logic [7:0]  addr;
      logic [15:0] wdata;
   } txn_t;

   typedef struct packed {
      logic [15:0] rdata;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_bus_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

   reg_bus_initiator #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .CMD_DEPTH (CMD_DEPTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   bit   in_reset = 1'b1;
   int   rdy_mode = 1;          // 0 random, 1 always ready, 2 held low

   txn_t exp_bus  [$];
   int   plan     [$];
   rsp_t exp_rsp  [$];
   int   exp_time [$];
   bit [15:0] model_mem [256];
   bit [15:0] slv_mem   [256];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a transaction acked within TIMEOUT cycles of its
   // request completes (writes update memory, reads return memory);
   // anything later is a timeout with zero data.
   task automatic send(bit w, logic [7:0] a, logic [15:0] d, int dly);
      int   guard = 0;
      rsp_t r;
      while (!bus_if.cmd_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      chk("cmd_accept_wait", bus_if.cmd_ready, 1);
      if (!bus_if.cmd_ready) return;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_write = w;
      bus_if.cmd_addr  = a;
      bus_if.cmd_wdata = d;
      exp_bus.push_back('{we: w, addr: a, wdata: d});
      plan.push_back(dly);
      if (dly <= TIMEOUT) begin
         if (w) begin
            model_mem[a] = d;
            r = '{rdata: 16'h0, err: 1'b0};
         end else begin
            r = '{rdata: model_mem[a], err: 1'b0};
         end
      end else begin
         r = '{rdata: 16'h0, err: 1'b1};
      end
      exp_rsp.push_back(r);
      @(negedge clk);
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_wdata = 16'($urandom);
   endtask

   task automatic wait_req(output int at);
      int g = 0;
      while (!bus_if.bus_req && g < 100) begin
         @(negedge clk);
         g++;
      end
      at = cyc;
      chk("bus_req_seen", bus_if.bus_req, 1);
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_rsp.size() != 0 || bus_if.rsp_valid) && g < 1000) begin
         @(negedge clk);
         g++;
      end
      chk("drain_pending", exp_rsp.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   // Slave: acks each request after the planned delay (offset 0 = in the
   // request cycle) and checks the request fields and their stability.
   initial begin : slave
      bit   active;
      int   r0;
      int   dly;
      int   off;
      txn_t cur;
      active = 1'b0;
      r0 = 0;
      dly = 0;
      cur = '0;
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = '0;
      forever begin
         @(negedge clk);
         #1;
         bus_if.bus_ack   = 1'b0;
         bus_if.bus_rdata = 16'($urandom);
         if (in_reset) begin
            active = 1'b0;
            continue;
         end
         if (active && (cyc - r0) > TIMEOUT + 2) active = 1'b0;
         if (bus_if.bus_req) begin
            chk("bus_req_while_busy", {31'b0, active}, 0);
            checks++;
            if (exp_bus.size() == 0 || plan.size() == 0) begin
               errors++;
               $display("FAIL spurious_bus_req: got req at cycle %0d expected none", cyc);
            end else begin
               cur = exp_bus.pop_front();
               dly = plan.pop_front();
               chk("bus_we",    bus_if.bus_we,    cur.we);
               chk("bus_addr",  bus_if.bus_addr,  cur.addr);
               chk("bus_wdata", bus_if.bus_wdata, cur.wdata);
               active = 1'b1;
               r0 = cyc;
               exp_time.push_back((dly <= TIMEOUT) ? cyc + dly + 1 : cyc + TIMEOUT + 1);
            end
         end
         if (active) begin
            off = cyc - r0;
            if (off > 0 && off <= TIMEOUT && off <= dly) begin
               chk("hold_addr",  bus_if.bus_addr,  cur.addr);
               chk("hold_we",    bus_if.bus_we,    cur.we);
               chk("hold_wdata", bus_if.bus_wdata, cur.wdata);
            end
            if (off == dly) begin
               bus_if.bus_ack = 1'b1;
               if (!cur.we) bus_if.bus_rdata = slv_mem[cur.addr];
               if (cur.we && dly <= TIMEOUT) slv_mem[cur.addr] = cur.wdata;
               active = 1'b0;
            end
         end
      end
   end

   initial begin : rdy_drv
      bus_if.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       bus_if.rsp_ready = ($urandom_range(3) != 0);
            1:       bus_if.rsp_ready = 1'b1;
            default: bus_if.rsp_ready = 1'b0;
         endcase
      end
   end

   initial begin : monitor
      bit   held;
      rsp_t last;
      rsp_t e;
      int   t;
      held = 1'b0;
      last = '0;
      forever begin
         @(negedge clk);
         #1;
         if (in_reset) begin
            held = 1'b0;
            continue;
         end
         if (bus_if.rsp_valid) begin
            chk("bus_req_during_rsp", bus_if.bus_req, 0);
            if (held) begin
               chk("rsp_rdata_stable", bus_if.rsp_rdata, last.rdata);
               chk("rsp_err_stable",   bus_if.rsp_err,   last.err);
            end else begin
               checks++;
               if (exp_rsp.size() == 0) begin
                  errors++;
                  $display("FAIL spurious_rsp: got rdata %0h err %0b expected no response",
                           bus_if.rsp_rdata, bus_if.rsp_err);
               end else begin
                  e = exp_rsp.pop_front();
                  t = (exp_time.size() != 0) ? exp_time.pop_front() : -1;
                  chk("rsp_rdata",   bus_if.rsp_rdata, e.rdata);
                  chk("rsp_err",     bus_if.rsp_err,   e.err);
                  chk("rsp_latency", cyc,              t);
               end
               last = '{rdata: bus_if.rsp_rdata, err: bus_if.rsp_err};
            end
            held = !bus_if.rsp_ready;
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int c0;
      int at;
      int r;
      int dly;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_write = 1'b0;
      bus_if.cmd_addr  = '0;
      bus_if.cmd_wdata = '0;

      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", bus_if.cmd_ready, 1);
      chk("rst_rsp_valid", bus_if.rsp_valid, 0);
      chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
      chk("rst_rsp_err",   bus_if.rsp_err,   0);
      chk("rst_bus_req",   bus_if.bus_req,   0);
      chk("rst_bus_we",    bus_if.bus_we,    0);
      chk("rst_bus_addr",  bus_if.bus_addr,  0);
      chk("rst_bus_wdata", bus_if.bus_wdata, 0);
      rst = 1'b0;
      in_reset = 1'b0;
      repeat (2) @(negedge clk);

      // write then read back, with request latency
      c0 = cyc;
      send(1'b1, 8'h10, 16'hBEEF, 2);
      wait_req(at);
      chk("req_latency", at - c0, 2);
      chk("t1_bus_we", bus_if.bus_we, 1);
      send(1'b0, 8'h10, 16'h0, 1);
      @(negedge clk);
      wait_req(at);
      chk("t1_read_we", bus_if.bus_we, 0);
      drain();

      // ack inside the request cycle
      c0 = cyc;
      send(1'b0, 8'h10, 16'h0, 0);
      wait_req(at);
      chk("req_latency_ack0", at - c0, 2);
      drain();

      // timeout, then a normal command
      send(1'b0, 8'h55, 16'h0, NEVER);
      send(1'b0, 8'h10, 16'h0, 3);
      drain();

      // FIFO full behind an in-flight transaction
      send(1'b1, 8'h30, 16'h1111, TIMEOUT - 2);
      send(1'b0, 8'h10, 16'h0,    1);
      send(1'b1, 8'h31, 16'h2222, 0);
      send(1'b0, 8'h31, 16'h0,    4);
      send(1'b1, 8'h32, 16'h3333, 2);
      chk("cmd_ready_full", bus_if.cmd_ready, 0);
      drain();

      // response back-pressure
      rdy_mode = 2;
      @(negedge clk);
      send(1'b0, 8'h10, 16'h0,    0);
      send(1'b1, 8'h40, 16'h7777, 0);
      at = 0;
      while (!bus_if.rsp_valid && at < 50) begin
         @(negedge clk);
         at++;
      end
      repeat (10) @(negedge clk);
      chk("bp_rsp_valid_held", bus_if.rsp_valid, 1);
      rdy_mode = 1;
      drain();

      // ack on the final cycle wins; a late ack is ignored
      send(1'b1, 8'h20, 16'h1234, 0);
      send(1'b0, 8'h20, 16'h0,    TIMEOUT);
      send(1'b0, 8'h20, 16'h0,    TIMEOUT + 1);
      send(1'b0, 8'h20, 16'h0,    TIMEOUT - 1);
      drain();

      // reset with one transaction waiting and two queued
      send(1'b1, 8'h60, 16'hDEAD, NEVER);
      send(1'b0, 8'h61, 16'h0,    NEVER);
      send(1'b1, 8'h62, 16'hCAFE, NEVER);
      repeat (3) @(negedge clk);
      in_reset = 1'b1;
      rst = 1'b1;
      #1;
      chk("mid_rst_bus_req",   bus_if.bus_req,   0);
      chk("mid_rst_rsp_valid", bus_if.rsp_valid, 0);
      chk("mid_rst_cmd_ready", bus_if.cmd_ready, 1);
      chk("mid_rst_bus_addr",  bus_if.bus_addr,  0);
      exp_bus.delete();
      plan.delete();
      exp_rsp.delete();
      exp_time.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      in_reset = 1'b0;
      repeat (20) @(negedge clk);
      send(1'b1, 8'h60, 16'hA5A5, 1);
      send(1'b0, 8'h60, 16'h0,    0);
      drain();

      // randomized traffic
      rdy_mode = 0;
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(9);
         if (r < 6)       dly = $urandom_range(4);
         else if (r == 6) dly = TIMEOUT;
         else if (r == 7) dly = TIMEOUT - 1;
         else if (r == 8) dly = TIMEOUT + 1 + $urandom_range(1);
         else             dly = NEVER;
         send(1'($urandom_range(1)), 8'h80 + 8'($urandom_range(7)), 16'($urandom), dly);
         if ($urandom_range(3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
      end
      rdy_mode = 1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
